// File: rtl/ps2_kb_rx_pkg.sv
// Shared widths, parameter defaults, receiver states and the PS/2 frame check.
package ps2_kb_rx_pkg;

    localparam int KbWidth     = 8;
    localparam int KbFifoDepth = 8;
    localparam int KbTimeout   = 50000;

    localparam int FRAME_BITS  = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    // Frame is {stop, parity, data[7:0], start}; odd parity over data+parity.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return !f[0] && f[FRAME_BITS-1] && (^f[FRAME_BITS-2:1]);
    endfunction

endpackage

// File: rtl/kb_fifo.sv
// Synchronous first-word-fall-through FIFO for received scan codes.
module kb_fifo
    import ps2_kb_rx_pkg::*;
#(
    parameter int DEPTH = KbFifoDepth,
    parameter int WIDTH = KbWidth,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame FSM with timeout,
// frame checker and scan-code FIFO feeding the MMIO read path.
module ps2_kb_rx
    import ps2_kb_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = KbFifoDepth,
    parameter int TIMEOUT    = KbTimeout
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               sig_rd_kb,
    output logic [KbWidth-1:0] kb_rdata,
    output logic               kb_ready,
    output logic               kb_overflow,
    output logic               kb_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    rx_state_e             state, state_nxt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [TW-1:0]         tmo_cnt;
    logic                  frame_done, frame_good, tmo_hit;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    assign frame_done = (bit_cnt == 4'(FRAME_BITS));
    assign frame_good = frame_done && frame_ok(shreg);
    assign tmo_hit    = (state == ST_RECV) && !fall && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fall) state_nxt = ST_RECV;
            ST_RECV: if (frame_done || tmo_hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a frame when the decoder pops in the same cycle.
    assign fifo_pop  = sig_rd_kb & ~fifo_empty;
    assign fifo_push = frame_good & (~fifo_full | fifo_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tmo_cnt     <= '0;
            kb_err      <= 1'b0;
            kb_overflow <= 1'b0;
        end else begin
            state       <= state_nxt;
            kb_err      <= frame_done & ~frame_good;
            kb_overflow <= kb_overflow | (frame_good & fifo_full & ~fifo_pop);
            if (frame_done || tmo_hit) begin
                bit_cnt <= '0;
            end else if (fall) begin
                shreg   <= {dat_s2, shreg[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state != ST_RECV || fall || tmo_hit) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    kb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KbWidth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (shreg[8:1]),
        .pop   (fifo_pop),
        .rdata (kb_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign kb_ready = (fifo_count != '0);

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: bit-banged PS/2 frames, scoreboard queue of
// expected scan codes, immediate-assertion checks.
module tb_ps2_kb_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int HP    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       sig_rd_kb = 1'b0;
    logic [7:0] kb_rdata;
    logic       kb_ready, kb_overflow, kb_err;

    int         n_vec = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    int         e0;
    logic [7:0] q[$];

    ps2_kb_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .sig_rd_kb   (sig_rd_kb),
        .kb_rdata    (kb_rdata),
        .kb_ready    (kb_ready),
        .kb_overflow (kb_overflow),
        .kb_err      (kb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && kb_err) err_cnt <= err_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed running required finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] d);
        if (q.size() < DEPTH) q.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v,
                              input int nbits, input bit pop_end);
        logic [10:0] f;
        f = {stop_v, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HP);
            ps2_clk = 1'b0;
            if (pop_end && i == 10) begin
                // Land the pop in the cycle the completed frame is checked.
                tick(3);
                sig_rd_kb = 1'b1;
                tick(1);
                sig_rd_kb = 1'b0;
                tick(HP - 4);
            end else begin
                tick(HP);
            end
            ps2_clk = 1'b1;
        end
        tick(HP);
        ps2_data = 1'b1;
        tick(4);
    endtask

    task automatic pop_check(input string tag);
        int         w;
        logic [7:0] exp;
        w = 0;
        while (!kb_ready && w < 200) begin
            tick(1);
            w++;
        end
        check({tag, "_rdy"}, kb_ready, 1);
        exp = (q.size() > 0) ? q.pop_front() : 8'h00;
        check(tag, kb_rdata, exp);
        sig_rd_kb = 1'b1;
        tick(1);
        sig_rd_kb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        q.delete();
        tick(1);
    endtask

    initial begin
        tick(3);
        check("rst_ready", kb_ready, 0);
        check("rst_rdata", kb_rdata, 0);
        check("rst_ovf", kb_overflow, 0);
        check("rst_err", kb_err, 0);
        rst_n = 1'b1;
        tick(2);

        // Good frame 0x1C
        send_frame(8'h1C, 0, 1, 11, 0);
        model_push(8'h1C);
        pop_check("good_1c");
        tick(1);
        check("good_empty", kb_ready, 0);
        check("good_no_err", err_cnt, 0);

        // Parity error
        e0 = err_cnt;
        send_frame(8'h1C, 1, 1, 11, 0);
        check("par_err", err_cnt, e0 + 1);
        check("par_ready", kb_ready, 0);

        // Stop-bit error
        e0 = err_cnt;
        send_frame(8'h1C, 0, 0, 11, 0);
        check("stop_err", err_cnt, e0 + 1);
        check("stop_ready", kb_ready, 0);

        // Ordering and overflow
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 0, 1, 11, 0);
            model_push(8'(i));
        end
        check("fill_ready", kb_ready, 1);
        check("fill_ovf", kb_overflow, 0);
        send_frame(8'h09, 0, 1, 11, 0);
        model_push(8'h09);
        check("ovf_set", kb_overflow, 1);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("order_%0d", i));
        tick(1);
        check("order_empty", kb_ready, 0);
        check("order_no_err", err_cnt, e0 + 1);

        // Simultaneous push and pop on a full FIFO
        do_reset();
        check("rst2_ovf", kb_overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 0, 1, 11, 0);
            model_push(8'(i));
        end
        check("pp_head", kb_rdata, q[0]);
        void'(q.pop_front());
        q.push_back(8'h0A);
        send_frame(8'h0A, 0, 1, 11, 1);
        check("pp_ovf", kb_overflow, 0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("pp_%0d", i));
        tick(1);
        check("pp_empty", kb_ready, 0);

        // Timeout on a partial frame
        e0 = err_cnt;
        send_frame(8'hFF, 0, 1, 5, 0);
        tick(TO + 10);
        send_frame(8'h5A, 0, 1, 11, 0);
        model_push(8'h5A);
        pop_check("tmo_5a");
        tick(1);
        check("tmo_empty", kb_ready, 0);
        check("tmo_no_err", err_cnt, e0);

        // Reset mid-frame
        send_frame(8'h77, 0, 1, 11, 0);
        check("mid_pre_ready", kb_ready, 1);
        send_frame(8'h33, 0, 1, 6, 0);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(HP);
        rst_n = 1'b0;
        tick(2);
        check("mid_ready", kb_ready, 0);
        check("mid_rdata", kb_rdata, 0);
        check("mid_ovf", kb_overflow, 0);
        check("mid_err", kb_err, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(2);
        rst_n = 1'b1;
        q.delete();
        tick(2);
        send_frame(8'hA5, 0, 1, 11, 0);
        model_push(8'hA5);
        pop_check("mid_a5");
        tick(1);
        check("mid_empty", kb_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
